// File: rtl/packet_sink.sv
// packet_sink: terminating endpoint for one network port. Checks delivered packets for
// misrouting and per-source ordering and accumulates windowed latency statistics.
`ifndef PORTS
`define PORTS 8
`endif

package packet_sink_pkg;
    localparam int PORT_W = (`PORTS > 1) ? $clog2(`PORTS) : 1;

    typedef struct packed {
        logic [PORT_W-1:0] dest;
        logic [PORT_W-1:0] source;
        logic [29:0]       data;
        logic              valid;
    } packet_t;
endpackage

module packet_sink
    import packet_sink_pkg::*;
#(
    parameter int unsigned port_no     = 0,
    parameter int unsigned WARMUP      = 600,
    parameter int unsigned MEASURE_END = 10600,
    parameter int unsigned DRAIN_END   = 20600,
    parameter int unsigned PORTS       = `PORTS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] timestamp,
    input  packet_t     pkt_in,
    output logic [31:0] pkt_count,
    output logic [47:0] lat_sum,
    output logic [29:0] lat_max,
    output logic [29:0] lat_min,
    output logic [15:0] late_count,
    output logic        measure_active,
    output logic        done,
    output logic        dest_error,
    output logic        order_error
);

    localparam logic [1:0] ST_WARMUP  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [PORT_W-1:0] PORT_ID = PORT_W'(port_no);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [31:0]       ts_ext;

    logic              s1_valid;
    logic [PORT_W-1:0] s1_dest;
    logic [PORT_W-1:0] s1_source;
    logic [29:0]       s1_data;
    logic [29:0]       s1_lat;

    logic [29:0]       last_stamp [PORTS];
    logic [PORTS-1:0]  seen;

    logic              src_ok;
    logic              counted;
    logic              late;
    logic              misrouted;
    logic              out_of_order;
    logic [48:0]       sum_ext;

    assign ts_ext = {2'b00, timestamp};

    always_comb begin
        state_next = state;
        case (state)
            ST_WARMUP:  if (ts_ext >= WARMUP)      state_next = ST_MEASURE;
            ST_MEASURE: if (ts_ext >= MEASURE_END) state_next = ST_DRAIN;
            ST_DRAIN:   if (ts_ext >= DRAIN_END)   state_next = ST_DONE;
            default:                               state_next = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_WARMUP;
            measure_active <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            measure_active <= (state_next == ST_MEASURE);
            done           <= (state_next == ST_DONE);
        end
    end

    // Latency is a modulo-2^30 subtract so a timestamp wrap still gives a small positive value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_dest   <= '0;
            s1_source <= '0;
            s1_data   <= '0;
            s1_lat    <= '0;
        end else begin
            s1_valid <= pkt_in.valid;
            if (pkt_in.valid) begin
                s1_dest   <= pkt_in.dest;
                s1_source <= pkt_in.source;
                s1_data   <= pkt_in.data;
                s1_lat    <= timestamp - pkt_in.data;
            end
        end
    end

    always_comb begin
        src_ok       = ({{(32-PORT_W){1'b0}}, s1_source} < PORTS);
        counted      = s1_valid && (state != ST_DONE) &&
                       ({2'b00, s1_data} >= WARMUP) && ({2'b00, s1_data} < MEASURE_END);
        late         = s1_valid && (state == ST_DONE);
        misrouted    = s1_valid && ((s1_dest != PORT_ID) || (s1_source == PORT_ID));
        out_of_order = s1_valid && src_ok && seen[s1_source] &&
                       (s1_data < last_stamp[s1_source]);
        sum_ext      = {1'b0, lat_sum} + {19'd0, s1_lat};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count   <= '0;
            lat_sum     <= '0;
            lat_max     <= '0;
            lat_min     <= 30'h3FFF_FFFF;
            late_count  <= '0;
            dest_error  <= 1'b0;
            order_error <= 1'b0;
        end else begin
            if (counted) begin
                if (pkt_count != '1) pkt_count <= pkt_count + 32'd1;
                lat_sum <= sum_ext[48] ? '1 : sum_ext[47:0];
                if (s1_lat > lat_max) lat_max <= s1_lat;
                if (s1_lat < lat_min) lat_min <= s1_lat;
            end
            if (late && (late_count != '1)) late_count <= late_count + 16'd1;
            if (misrouted)    dest_error  <= 1'b1;
            if (out_of_order) order_error <= 1'b1;
        end
    end

    // Each source's newest stamp is recorded even when it was out of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PORTS); i++) last_stamp[i] <= '0;
            seen <= '0;
        end else if (s1_valid && src_ok) begin
            last_stamp[s1_source] <= s1_data;
            seen[s1_source]       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_packet_sink.sv
// tb_packet_sink: directed vector table, mid-stream reset, timestamp wrap and a randomized
// run compared against a behavioural model of the sink's rules.
`ifndef PORTS
`define PORTS 8
`endif

module tb_packet_sink;
    import packet_sink_pkg::*;

    localparam int unsigned PORT        = 3;
    localparam int unsigned WARMUP      = 600;
    localparam int unsigned MEASURE_END = 10600;
    localparam int unsigned DRAIN_END   = 20600;
    localparam int          NV          = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] timestamp;
    packet_t     pkt_in;

    logic [31:0] pkt_count, w_pkt_count;
    logic [47:0] lat_sum, w_lat_sum;
    logic [29:0] lat_max, w_lat_max;
    logic [29:0] lat_min, w_lat_min;
    logic [15:0] late_count, w_late_count;
    logic        measure_active, w_measure_active;
    logic        done, w_done;
    logic        dest_error, w_dest_error;
    logic        order_error, w_order_error;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [29:0]       ts;
        logic [PORT_W-1:0] dest;
        logic [PORT_W-1:0] src;
        logic [29:0]       data;
        logic [31:0]       cnt;
        logic [47:0]       sum;
        logic [29:0]       lmax;
        logic [29:0]       lmin;
        logic [15:0]       late;
        logic              oerr;
        logic              derr;
        logic              meas;
        logic              dn;
    } vec_t;

    vec_t vecs [NV];

    int unsigned     m_cnt, m_max, m_min, m_late;
    longint unsigned m_sum;
    bit              m_derr, m_oerr;
    int unsigned     m_last [`PORTS];
    bit              m_seen [`PORTS];

    bit          pv    [4];
    int unsigned pdest [4];
    int unsigned psrc  [4];
    int unsigned pdata [4];

    always #5 clk = ~clk;

    packet_sink #(
        .port_no(PORT), .WARMUP(WARMUP), .MEASURE_END(MEASURE_END),
        .DRAIN_END(DRAIN_END), .PORTS(`PORTS)
    ) dut (
        .clk(clk), .rst(rst), .timestamp(timestamp), .pkt_in(pkt_in),
        .pkt_count(pkt_count), .lat_sum(lat_sum), .lat_max(lat_max), .lat_min(lat_min),
        .late_count(late_count), .measure_active(measure_active), .done(done),
        .dest_error(dest_error), .order_error(order_error)
    );

    // Window placed at the very top of the stamp range so a wrapped packet is counted.
    packet_sink #(
        .port_no(PORT), .WARMUP(32'h3FFF_FF00), .MEASURE_END(32'h4000_0000),
        .DRAIN_END(32'h4000_0000), .PORTS(`PORTS)
    ) wrap_dut (
        .clk(clk), .rst(rst), .timestamp(timestamp), .pkt_in(pkt_in),
        .pkt_count(w_pkt_count), .lat_sum(w_lat_sum), .lat_max(w_lat_max), .lat_min(w_lat_min),
        .late_count(w_late_count), .measure_active(w_measure_active), .done(w_done),
        .dest_error(w_dest_error), .order_error(w_order_error)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [29:0] ts, input logic v,
                                 input logic [PORT_W-1:0] d, input logic [PORT_W-1:0] s,
                                 input logic [29:0] data);
        timestamp     = ts;
        pkt_in.valid  = v;
        pkt_in.dest   = d;
        pkt_in.source = s;
        pkt_in.data   = data;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(30'd0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".pkt_count"},      pkt_count,      64'd0);
        checkOutput({tag, ".lat_sum"},        lat_sum,        64'd0);
        checkOutput({tag, ".lat_max"},        lat_max,        64'd0);
        checkOutput({tag, ".lat_min"},        lat_min,        64'h3FFF_FFFF);
        checkOutput({tag, ".late_count"},     late_count,     64'd0);
        checkOutput({tag, ".measure_active"}, measure_active, 64'd0);
        checkOutput({tag, ".done"},           done,           64'd0);
        checkOutput({tag, ".dest_error"},     dest_error,     64'd0);
        checkOutput({tag, ".order_error"},    order_error,    64'd0);
    endtask

    task automatic checkVector(input int i);
        string tag;
        tag = $sformatf("vec%0d", i);
        checkOutput({tag, ".pkt_count"},      pkt_count,      vecs[i].cnt);
        checkOutput({tag, ".lat_sum"},        lat_sum,        vecs[i].sum);
        checkOutput({tag, ".lat_max"},        lat_max,        vecs[i].lmax);
        checkOutput({tag, ".lat_min"},        lat_min,        vecs[i].lmin);
        checkOutput({tag, ".late_count"},     late_count,     vecs[i].late);
        checkOutput({tag, ".order_error"},    order_error,    vecs[i].oerr);
        checkOutput({tag, ".dest_error"},     dest_error,     vecs[i].derr);
        checkOutput({tag, ".measure_active"}, measure_active, vecs[i].meas);
        checkOutput({tag, ".done"},           done,           vecs[i].dn);
    endtask

    task automatic modelClear();
        m_cnt = 0; m_sum = 0; m_max = 0; m_min = 32'h3FFF_FFFF; m_late = 0;
        m_derr = 0; m_oerr = 0;
        for (int i = 0; i < `PORTS; i++) begin
            m_last[i] = 0;
            m_seen[i] = 0;
        end
        for (int i = 0; i < 4; i++) pv[i] = 0;
    endtask

    // A packet that reaches the sink after the drain deadline is late; otherwise its
    // injection stamp alone decides whether it belongs to the measurement window.
    task automatic modelAccept(input int unsigned arr, input int unsigned dest,
                               input int unsigned src, input int unsigned data);
        int unsigned lat;
        lat = (arr - data) & 32'h3FFF_FFFF;
        if (arr >= DRAIN_END) begin
            if (m_late < 32'hFFFF) m_late++;
        end else if (data >= WARMUP && data < MEASURE_END) begin
            m_cnt++;
            m_sum += lat;
            if (lat > m_max) m_max = lat;
            if (lat < m_min) m_min = lat;
        end
        if (dest != PORT || src == PORT) m_derr = 1;
        if (m_seen[src] && data < m_last[src]) m_oerr = 1;
        m_last[src] = data;
        m_seen[src] = 1;
    endtask

    task automatic checkModel(input int t);
        string tag;
        tag = $sformatf("rand@%0d", t);
        checkOutput({tag, ".pkt_count"},      pkt_count,      m_cnt);
        checkOutput({tag, ".lat_sum"},        lat_sum,        m_sum);
        checkOutput({tag, ".lat_max"},        lat_max,        m_max);
        checkOutput({tag, ".lat_min"},        lat_min,        m_min);
        checkOutput({tag, ".late_count"},     late_count,     m_late);
        checkOutput({tag, ".dest_error"},     dest_error,     m_derr);
        checkOutput({tag, ".order_error"},    order_error,    m_oerr);
        checkOutput({tag, ".measure_active"}, measure_active,
                    (t - 1 >= int'(WARMUP)) && (t - 1 < int'(MEASURE_END)));
        checkOutput({tag, ".done"},           done,           t - 1 >= int'(DRAIN_END));
    endtask

    initial begin
        // arrival ts, dest, src, data -> cumulative expectations two edges later
        vecs[0] = '{30'd725,   PORT_W'(3), PORT_W'(1), 30'd700,   32'd1, 48'd25,  30'd25,  30'd25, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{30'd730,   PORT_W'(3), PORT_W'(4), 30'd599,   32'd1, 48'd25,  30'd25,  30'd25, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{30'd950,   PORT_W'(3), PORT_W'(2), 30'd900,   32'd2, 48'd75,  30'd50,  30'd25, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{30'd960,   PORT_W'(3), PORT_W'(2), 30'd850,   32'd3, 48'd185, 30'd110, 30'd25, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{30'd1000,  PORT_W'(5), PORT_W'(1), 30'd990,   32'd4, 48'd195, 30'd110, 30'd10, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{30'd10650, PORT_W'(3), PORT_W'(6), 30'd10600, 32'd4, 48'd195, 30'd110, 30'd10, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{30'd10700, PORT_W'(3), PORT_W'(7), 30'd10590, 32'd5, 48'd305, 30'd110, 30'd10, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{30'd20700, PORT_W'(3), PORT_W'(1), 30'd20650, 32'd5, 48'd305, 30'd110, 30'd10, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b0;
        applyStimulus(30'd0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;

        // Directed pass: free-running timestamp with the vector table overlaid.
        for (int t = 0; t <= 20800; t++) begin
            int hi;
            hi = -1;
            @(negedge clk);
            for (int i = 0; i < NV; i++)
                if (int'(vecs[i].ts) + 2 == t) checkVector(i);
            if (t == 100) begin
                checkOutput("idle.pkt_count", pkt_count, 64'd0);
                checkOutput("idle.lat_min", lat_min, 64'h3FFF_FFFF);
                checkOutput("idle.measure_active", measure_active, 64'd0);
            end
            if (t == 600)   checkOutput("meas_before_600", measure_active, 64'd0);
            if (t == 601)   checkOutput("meas_after_600", measure_active, 64'd1);
            if (t == 10601) checkOutput("meas_after_end", measure_active, 64'd0);
            if (t == 20600) checkOutput("done_before_20600", done, 64'd0);
            if (t == 20601) checkOutput("done_after_20600", done, 64'd1);
            for (int i = 0; i < NV; i++)
                if (int'(vecs[i].ts) == t) hi = i;
            if (hi >= 0)
                applyStimulus(30'(t), 1'b1, vecs[hi].dest, vecs[hi].src, vecs[hi].data);
            else
                applyStimulus(30'(t), 1'b0, '0, '0, '0);
        end

        // Reset while a windowed packet sits in stage 1: it must be discarded.
        @(negedge clk);
        applyStimulus(30'd20801, 1'b1, PORT_W'(3), PORT_W'(1), 30'd5000);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(30'd0, 1'b0, '0, '0, '0);
        #1 checkResetValues("midreset");
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("flush.pkt_count", pkt_count, 64'd0);
        checkOutput("flush.lat_sum", lat_sum, 64'd0);
        checkOutput("flush.late_count", late_count, 64'd0);

        // Randomized pass against the model.
        doReset();
        modelClear();
        for (int t = 0; t <= 21000; t++) begin
            int unsigned lat, d, s, data;
            @(negedge clk);
            if (t >= 2 && pv[(t - 2) % 4]) begin
                modelAccept(t - 2, pdest[(t - 2) % 4], psrc[(t - 2) % 4], pdata[(t - 2) % 4]);
                pv[(t - 2) % 4] = 0;
            end
            if (t >= 8 && t % 8 == 0) checkModel(t);
            if ($urandom_range(0, 1) == 1 && (t < 20598 || t > 20602)) begin
                s = $urandom_range(0, `PORTS - 1);
                if (s == PORT && $urandom_range(0, 15) != 0) s = 2;
                d = ($urandom_range(0, 31) == 0) ? $urandom_range(0, `PORTS - 1) : PORT;
                lat = $urandom_range(0, 400);
                data = (t >= int'(lat)) ? t - lat : 0;
                pv[t % 4] = 1; pdest[t % 4] = d; psrc[t % 4] = s; pdata[t % 4] = data;
                applyStimulus(30'(t), 1'b1, PORT_W'(d), PORT_W'(s), 30'(data));
            end else begin
                applyStimulus(30'(t), 1'b0, '0, '0, '0);
            end
        end

        // Timestamp wrap: stamp 3FFFFFF0 delivered at 10 is 32 cycles old.
        doReset();
        @(negedge clk);
        applyStimulus(30'h10, 1'b1, PORT_W'(3), PORT_W'(1), 30'h3FFF_FFF0);
        @(negedge clk);
        applyStimulus(30'h11, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("wrap.pkt_count", w_pkt_count, 64'd1);
        checkOutput("wrap.lat_sum", w_lat_sum, 64'd32);
        checkOutput("wrap.lat_max", w_lat_max, 64'd32);
        checkOutput("wrap.lat_min", w_lat_min, 64'd32);
        checkOutput("wrap.late_count", w_late_count, 64'd0);
        checkOutput("wrap.measure_active", w_measure_active, 64'd0);
        checkOutput("wrap.done", w_done, 64'd0);
        checkOutput("wrap.dest_error", w_dest_error, 64'd0);
        checkOutput("wrap.order_error", w_order_error, 64'd0);
        checkOutput("wrap.main_pkt_count", pkt_count, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/packet_sink.md
Name: packet_sink

Overview:
- Terminating endpoint attached to one network output port; the receive-side counterpart of the per-port traffic generator.
- Accepts the delivered packet_t stream and checks each packet for misrouting and per-source ordering.
- Computes network latency from the embedded 30-bit injection timestamp.
- Accumulates windowed latency statistics (warm-up / measure / drain) for the testbench and the statistics collector.

Parameters:
- port_no, 0, index of the network port this sink is attached to.
- WARMUP, 600, first injection timestamp counted in statistics.
- MEASURE_END, 10600, first injection timestamp excluded after the window.
- DRAIN_END, 20600, global timestamp at which the sink declares done.
- PORTS, `PORTS, number of network ports; source/dest field width is log2(PORTS).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (asserted at rst==0).
- timestamp  input  30  global free-running cycle count, shared with all sources.
- pkt_in  input  packet_t  delivered packet: dest, source, data[29:0] = injection timestamp, valid.
- pkt_count  output  32  packets counted inside the measurement window.
- lat_sum  output  48  sum of latencies of counted packets.
- lat_max  output  30  maximum counted latency.
- lat_min  output  30  minimum counted latency.
- late_count  output  16  packets received after DONE.
- measure_active  output  1  high while the FSM is in MEASURE.
- done  output  1  high while the FSM is in DONE.
- dest_error  output  1  sticky: a packet arrived with dest != port_no, or with source == port_no.
- order_error  output  1  sticky: a source delivered an injection stamp older than its previous one.

Behaviour:
- Reset values (rst==0, immediate): all counts, lat_sum and lat_max = 0; lat_min = 30'h3FFFFFFF; all flags = 0; FSM = WARMUP; per-source last-stamp table cleared to 0 with all "seen" bits cleared.
- Acceptance: the sink has no backpressure. At most one packet per cycle. A packet is accepted on any rising clk where pkt_in.valid=1.
- Pipeline, stage 1 (registered on the arrival cycle):
  - capture dest, source, data;
  - latency = (timestamp - data) mod 2^30, a 30-bit unsigned subtract, so timestamp wrap-around yields the correct small positive value.
- Pipeline, stage 2 (next cycle): update statistics, errors and the order table. All outputs reflect a packet 2 cycles after its arrival edge.
- FSM (evaluated on the global timestamp every cycle):
  - WARMUP -> MEASURE when timestamp >= WARMUP.
  - MEASURE -> DRAIN when timestamp >= MEASURE_END.
  - DRAIN -> DONE when timestamp >= DRAIN_END.
  - DONE is terminal until reset.
  - measure_active = (state==MEASURE); done = (state==DONE); both are registered.
- Counting rule: a packet is counted iff WARMUP <= data < MEASURE_END and the FSM is not in DONE at stage 2. The window is keyed on the packet's injection stamp, not on its arrival time, so packets injected in the window still count when they arrive during DRAIN.
- Statistics update for a counted packet:
  - pkt_count += 1, saturating at 2^32-1;
  - lat_sum += latency, zero-extended, saturating at 2^48-1;
  - lat_max = max(lat_max, latency);
  - lat_min = min(lat_min, latency).
- Packets arriving in DONE are not counted; instead late_count += 1, saturating at 16'hFFFF.
- dest_error: set when a valid packet has dest != port_no, or source == port_no. Never cleared except by reset. Such packets still update the statistics.
- order_error:
  - per source s, keep last[s] (30 bits) and seen[s];
  - if seen[s] and data < last[s], set order_error;
  - always write last[s] = data and seen[s] = 1;
  - comparison is plain unsigned (runs do not span a 2^30 wrap).
- Reset mid-operation: the pipeline is flushed; a packet in flight at reset is discarded and not counted.
- Back-to-back packets every cycle are fully pipelined; there are no stalls and no drops.

Test Plan:
- Reset, then hold idle -> pkt_count=0, lat_min=3FFFFFFF, FSM=WARMUP; measure_active=1 on the cycle after timestamp first reads 600.
- port_no=3. Packet {dest=3, src=1, data=700} arrives at timestamp=725 -> 2 cycles later pkt_count=1, lat_sum=25, lat_max=25, lat_min=25, no errors.
- Packets with data=599, 700 and 10600, each arriving during MEASURE or DRAIN -> only data=700 is counted; pkt_count=1.
- data=30'h3FFFFFF0 arriving at timestamp=30'h00000010 -> latency=32 (wrap).
- Source 2 delivers data=900 then data=850 -> order_error=1 and stays high. Packet with dest=5 at port_no=3 -> dest_error=1.
- timestamp reaches 20600 -> done=1. A packet arriving afterwards -> late_count=1, pkt_count unchanged. Assert rst=0 mid-stream -> all outputs return to reset values immediately.
